// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file and its scoreboard.
package mips_pkg;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending write-back and their population count.
module reg_scoreboard #(
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int unsigned NREG   = mips_pkg::NREG
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NREG-1:0]   busy,
  output logic [ADDR_W:0]   busy_count
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(mips_pkg::REG_ZERO);

  logic [NREG-1:0] busy_d, busy_q;
  logic [ADDR_W:0] count_d, count_q;

  // Clear first so a same-cycle reserve on the same index leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_addr != ZERO) busy_d[clr_addr] = 1'b0;
    if (rsv_en && rsv_addr != ZERO) busy_d[rsv_addr] = 1'b1;
    busy_d[ZERO] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NREG; i++) count_d = count_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;
endmodule

// File: rtl/regfile_read_port.sv
// Register file read side: storage, two registered read ports with write-back bypass,
// and a stall when an operand's producer has not yet written back.
module regfile_read_port #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int unsigned NREG   = mips_pkg::NREG
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  output logic              stall,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   busy_count
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(mips_pkg::REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              rs_hz, rt_hz;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .areset_n   (areset_n),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .clr_en     (wr_en),
    .clr_addr   (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // A write-back landing this cycle resolves the hazard via the bypass path.
  always_comb begin
    rs_hz = (rs_addr != ZERO) && busy[rs_addr] && !(wr_en && wr_addr == rs_addr);
    rt_hz = (rt_addr != ZERO) && busy[rt_addr] && !(wr_en && wr_addr == rt_addr);
    stall = rd_en && (rs_hz || rt_hz);
  end

  always_comb begin
    if (rs_addr == ZERO)                   rs_val = '0;
    else if (wr_en && wr_addr == rs_addr)  rs_val = wr_data;
    else                                   rs_val = regs_q[rs_addr];
    if (rt_addr == ZERO)                   rt_val = '0;
    else if (wr_en && wr_addr == rt_addr)  rt_val = wr_data;
    else                                   rt_val = regs_q[rt_addr];
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != ZERO) regs_d[wr_addr] = wr_data;
  end

  always_comb begin
    rd_valid_d = rd_en && !stall;
    rs_data_d  = rd_valid_d ? rs_val : rs_data_q;
    rt_data_d  = rd_valid_d ? rt_val : rt_data_q;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign rd_valid = rd_valid_q;
endmodule
